// File: rtl/frame_stream_scheduler.sv
// Frame sequencer: start-up window, per-row gaps and the pixel-pair strobe
// with row/column indices and the byte address of each pair's even pixel.
module frame_stream_scheduler #(
    parameter int IMAGE_WIDTH    = 768,
    parameter int IMAGE_HEIGHT   = 512,
    parameter int START_UP_DELAY = 100,
    parameter int HSYNC_DELAY    = 160,
    parameter int ROW_BITS       = 9,
    parameter int COL_BITS       = 9,
    parameter int ADDR_BITS      = 21
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stall,
    output logic                 vertical_Sync,
    output logic                 horizontal_Pulse,
    output logic [ROW_BITS-1:0]  row_Index,
    output logic [COL_BITS-1:0]  col_Index,
    output logic [ADDR_BITS-1:0] pixel_Address,
    output logic                 busy,
    output logic                 frame_Done
);

    localparam int MAX_DELAY = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
    localparam int CNT_BITS  = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

    localparam logic [CNT_BITS-1:0]  STARTUP_LAST = CNT_BITS'(START_UP_DELAY - 1);
    localparam logic [CNT_BITS-1:0]  HSYNC_LAST   = CNT_BITS'(HSYNC_DELAY - 1);
    localparam logic [COL_BITS-1:0]  COL_LAST     = COL_BITS'(IMAGE_WIDTH / 2 - 1);
    localparam logic [ROW_BITS-1:0]  ROW_LAST     = ROW_BITS'(IMAGE_HEIGHT - 1);
    localparam logic [ADDR_BITS-1:0] PAIR_BYTES   = ADDR_BITS'(6);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STARTUP,
        S_HSYNC_GAP,
        S_ACTIVE,
        S_FRAME_END
    } state_t;

    state_t               state_q;
    logic [CNT_BITS-1:0]  cnt_q;
    logic [ROW_BITS-1:0]  row_q;
    logic [COL_BITS-1:0]  col_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 vsync_q;
    logic                 busy_q;
    logic                 done_q;

    logic [CNT_BITS-1:0]  cnt_d;
    logic [ROW_BITS-1:0]  row_d;
    logic [COL_BITS-1:0]  col_d;
    logic [ADDR_BITS-1:0] addr_d;
    logic                 pulse;

    // Rows are stored back to back, so the address simply walks in pair-sized steps.
    always_comb begin
        cnt_d  = cnt_q + CNT_BITS'(1);
        row_d  = row_q + ROW_BITS'(1);
        col_d  = col_q + COL_BITS'(1);
        addr_d = addr_q + PAIR_BYTES;
        pulse  = (state_q == S_ACTIVE) & ~stall;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
            vsync_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_STARTUP;
                        cnt_q   <= '0;
                        row_q   <= '0;
                        col_q   <= '0;
                        addr_q  <= '0;
                        vsync_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_STARTUP: begin
                    if (cnt_q == STARTUP_LAST) begin
                        state_q <= S_HSYNC_GAP;
                        cnt_q   <= '0;
                        vsync_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_HSYNC_GAP: begin
                    if (cnt_q == HSYNC_LAST) begin
                        state_q <= S_ACTIVE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_ACTIVE: begin
                    // A stalled cycle leaves state, indices and address untouched.
                    if (pulse) begin
                        if (col_q == COL_LAST) begin
                            if (row_q == ROW_LAST) begin
                                state_q <= S_FRAME_END;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_HSYNC_GAP;
                                row_q   <= row_d;
                                col_q   <= '0;
                                addr_q  <= addr_d;
                            end
                        end else begin
                            col_q  <= col_d;
                            addr_q <= addr_d;
                        end
                    end
                end
                S_FRAME_END: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign vertical_Sync    = vsync_q;
    assign horizontal_Pulse = pulse;
    assign row_Index        = row_q;
    assign col_Index        = col_q;
    assign pixel_Address    = addr_q;
    assign busy             = busy_q;
    assign frame_Done       = done_q;

endmodule

// File: tb/tb_frame_stream_scheduler.sv
// Bench for frame_stream_scheduler with a small frame (8x4, start-up 3, gap 2);
// expectations come from a timeline model built from the frame timing rules.
module tb_frame_stream_scheduler;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int D  = 3;
    localparam int G  = 2;
    localparam int HP = W / 2;
    localparam int N  = HP * H;
    localparam int RB = 9;
    localparam int CB = 9;
    localparam int AB = 21;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic          vertical_Sync;
    logic          horizontal_Pulse;
    logic [RB-1:0] row_Index;
    logic [CB-1:0] col_Index;
    logic [AB-1:0] pixel_Address;
    logic          busy;
    logic          frame_Done;

    always #5 clk = ~clk;

    frame_stream_scheduler #(
        .IMAGE_WIDTH   (W),
        .IMAGE_HEIGHT  (H),
        .START_UP_DELAY(D),
        .HSYNC_DELAY   (G),
        .ROW_BITS      (RB),
        .COL_BITS      (CB),
        .ADDR_BITS     (AB)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .stall           (stall),
        .vertical_Sync   (vertical_Sync),
        .horizontal_Pulse(horizontal_Pulse),
        .row_Index       (row_Index),
        .col_Index       (col_Index),
        .pixel_Address   (pixel_Address),
        .busy            (busy),
        .frame_Done      (frame_Done)
    );

    int errors = 0;
    int checks = 0;

    // Timeline model: edge counter plus the edges at which each phase begins.
    int e            = 0;
    bit m_run        = 1'b0;
    int m_start_edge = 0;
    int m_ready_edge = 0;
    int m_k          = 0;
    int m_end_edge   = -1;
    bit prev_pulse   = 1'b0;
    bit prev_idle    = 1'b1;
    bit exp_vsync, exp_active, exp_pulse, exp_done, exp_busy;
    bit exp_zero     = 1'b0;
    int exp_row, exp_col, exp_addr;

    task automatic step(input logic st, input logic sl, input logic rn);
        @(posedge clk);
        e++;
        if (!reset) begin
            m_run      = 1'b0;
            m_end_edge = -1;
            m_k        = 0;
            exp_zero   = 1'b1;
        end else begin
            exp_zero = 1'b0;
            if (prev_pulse) begin
                m_k++;
                if (m_k % HP == 0) begin
                    if (m_k == N) begin
                        m_run      = 1'b0;
                        m_end_edge = e;
                    end else begin
                        m_ready_edge = e + G;
                    end
                end
            end
            if (prev_idle && start) begin
                m_run        = 1'b1;
                m_start_edge = e;
                m_ready_edge = e + D + G;
                m_k          = 0;
            end
        end
        #1;
        start = st;
        stall = sl;
        reset = rn;
        @(negedge clk);
        exp_vsync  = m_run && (e < m_start_edge + D);
        exp_active = m_run && (e >= m_ready_edge);
        exp_pulse  = exp_active && !stall;
        exp_done   = (m_end_edge == e);
        exp_busy   = m_run || exp_done;
        exp_row    = m_k / HP;
        exp_col    = m_k % HP;
        exp_addr   = exp_row * W * 3 + exp_col * 6;
        prev_pulse = exp_pulse;
        prev_idle  = !exp_busy;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if ({vertical_Sync, horizontal_Pulse, busy, frame_Done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got=%b want=0000", {vertical_Sync, horizontal_Pulse, busy, frame_Done});
        end
        checks++;
        if (row_Index !== '0 || col_Index !== '0 || pixel_Address !== '0) begin
            errors++;
            $display("FAIL reset_indices got row=%0d col=%0d addr=%0d want 0/0/0", row_Index, col_Index, pixel_Address);
        end
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy got=%b want=0", busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_first_pulse();
        step(1'b1, 1'b0, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            step(1'b0, 1'b0, 1'b1);
            checks++;
            if (vertical_Sync !== (c <= 3)) begin
                errors++;
                $display("FAIL vsync_window cycle=%0d got=%b want=%b", c, vertical_Sync, c <= 3);
            end
            checks++;
            if (horizontal_Pulse !== (c == 6)) begin
                errors++;
                $display("FAIL first_pulse cycle=%0d got=%b want=%b", c, horizontal_Pulse, c == 6);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL startup_busy cycle=%0d got=%b want=1", c, busy);
            end
        end
        checks++;
        if (row_Index !== '0 || col_Index !== '0 || pixel_Address !== '0) begin
            errors++;
            $display("FAIL first_pulse_pos got row=%0d col=%0d addr=%0d want 0/0/0", row_Index, col_Index, pixel_Address);
        end
        for (int i = 0; i < 200 && busy; i++) step(1'b0, 1'b0, 1'b1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL first_frame_timeout busy=%b want=0", busy);
        end
        $display("test_first_pulse done");
    endtask

    task automatic test_full_frame();
        int npulse = 0, ndone = 0, last_pulse_c = -10, done_c = -10;
        int last_addr = -1, last_row = 0;
        step(1'b1, 1'b0, 1'b1);
        for (int c = 1; c <= 60; c++) begin
            step(1'b0, 1'b0, 1'b1);
            if (horizontal_Pulse) begin
                checks++;
                if (pixel_Address !== AB'(npulse * 6)) begin
                    errors++;
                    $display("FAIL frame_addr pulse=%0d got=%0d want=%0d", npulse, pixel_Address, npulse * 6);
                end
                if (npulse > 0 && int'(row_Index) != last_row) begin
                    checks++;
                    if (c - last_pulse_c - 1 != G) begin
                        errors++;
                        $display("FAIL row_gap row=%0d got=%0d want=%0d", row_Index, c - last_pulse_c - 1, G);
                    end
                end
                last_row     = int'(row_Index);
                last_addr    = int'(pixel_Address);
                last_pulse_c = c;
                npulse++;
            end
            if (frame_Done) begin
                ndone++;
                done_c = c;
                checks++;
                if (c != last_pulse_c + 1) begin
                    errors++;
                    $display("FAIL done_timing got_cycle=%0d want_cycle=%0d", c, last_pulse_c + 1);
                end
            end
            if (c == done_c + 1) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_after_done got=%b want=0", busy);
                end
            end
        end
        checks++;
        if (npulse != N || last_addr != 90 || ndone != 1) begin
            errors++;
            $display("FAIL frame_totals got pulses=%0d last_addr=%0d dones=%0d want %0d/90/1", npulse, last_addr, ndone, N);
        end
        $display("test_full_frame done");
    endtask

    task automatic test_stall();
        int npulse = 0;
        step(1'b1, 1'b0, 1'b1);
        for (int c = 1; c <= 60; c++) begin
            step(1'b0, (c >= 14 && c <= 16), 1'b1);
            if (horizontal_Pulse) npulse++;
            if (c >= 14 && c <= 16) begin
                checks++;
                if (horizontal_Pulse !== 1'b0 || row_Index !== RB'(1) || col_Index !== CB'(2) || pixel_Address !== AB'(36)) begin
                    errors++;
                    $display("FAIL stall_hold cycle=%0d got pulse=%b row=%0d col=%0d addr=%0d want 0/1/2/36",
                             c, horizontal_Pulse, row_Index, col_Index, pixel_Address);
                end
            end
            if (c == 17) begin
                checks++;
                if (horizontal_Pulse !== 1'b1 || pixel_Address !== AB'(36)) begin
                    errors++;
                    $display("FAIL stall_resume got pulse=%b addr=%0d want 1/36", horizontal_Pulse, pixel_Address);
                end
            end
        end
        checks++;
        if (npulse != N || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_total got pulses=%0d busy=%b want %0d/0", npulse, busy, N);
        end
        $display("test_stall done");
    endtask

    task automatic test_back_to_back();
        int ndone = 0, last_done = -10, npulse = 0;
        for (int c = 1; c <= 90; c++) begin
            step(1'b1, 1'b0, 1'b1);
            if (horizontal_Pulse) npulse++;
            if (c == last_done + 1) begin
                checks++;
                if (busy !== 1'b0 || vertical_Sync !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_idle cycle=%0d got busy=%b vsync=%b want 0/0", c, busy, vertical_Sync);
                end
            end
            if (c == last_done + 2) begin
                checks++;
                if (busy !== 1'b1 || vertical_Sync !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_restart cycle=%0d got busy=%b vsync=%b want 1/1", c, busy, vertical_Sync);
                end
            end
            if (frame_Done) begin
                checks++;
                if (c != 29 * (ndone + 1) || npulse != N) begin
                    errors++;
                    $display("FAIL b2b_frame got done_cycle=%0d pulses=%0d want %0d/%0d", c, npulse, 29 * (ndone + 1), N);
                end
                ndone++;
                npulse    = 0;
                last_done = c;
            end
        end
        checks++;
        if (ndone != 3) begin
            errors++;
            $display("FAIL b2b_count got=%0d want=3", ndone);
        end
        for (int i = 0; i < 200 && busy; i++) step(1'b0, 1'b0, 1'b1);
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_abort();
        int ndone = 0, npulse = 0;
        step(1'b1, 1'b0, 1'b1);
        for (int c = 1; c <= 19; c++) step(1'b0, 1'b0, (c != 19));
        checks++;
        if (row_Index !== RB'(2) || col_Index !== CB'(1) || horizontal_Pulse !== 1'b1) begin
            errors++;
            $display("FAIL abort_position got row=%0d col=%0d pulse=%b want 2/1/1", row_Index, col_Index, horizontal_Pulse);
        end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if ({vertical_Sync, horizontal_Pulse, busy, frame_Done} !== 4'b0000 ||
            row_Index !== '0 || col_Index !== '0 || pixel_Address !== '0) begin
            errors++;
            $display("FAIL abort_clear got flags=%b row=%0d col=%0d addr=%0d want all 0",
                     {vertical_Sync, horizontal_Pulse, busy, frame_Done}, row_Index, col_Index, pixel_Address);
        end
        for (int c = 0; c < 30; c++) begin
            step(1'b0, 1'b0, 1'b1);
            if (frame_Done || busy) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL abort_no_done got active_cycles=%0d want=0", ndone);
        end
        step(1'b1, 1'b0, 1'b1);
        for (int c = 1; c <= 40; c++) begin
            step(1'b0, 1'b0, 1'b1);
            if (horizontal_Pulse) begin
                checks++;
                if (pixel_Address !== AB'(npulse * 6)) begin
                    errors++;
                    $display("FAIL clean_addr pulse=%0d got=%0d want=%0d", npulse, pixel_Address, npulse * 6);
                end
                npulse++;
            end
            if (frame_Done) ndone++;
        end
        checks++;
        if (npulse != N || ndone != 1) begin
            errors++;
            $display("FAIL clean_frame got pulses=%0d dones=%0d want %0d/1", npulse, ndone, N);
        end
        $display("test_reset_abort done");
    endtask

    task automatic test_random_stall();
        int cnt = 0, frames = 0;
        bit vs_prev = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 9) == 0), ($urandom_range(0, 99) < 30), ($urandom_range(0, 599) != 0));
            checks++;
            if (vertical_Sync !== exp_vsync || horizontal_Pulse !== exp_pulse ||
                busy !== exp_busy || frame_Done !== exp_done) begin
                errors++;
                $display("FAIL rand_flags cycle=%0d got vs=%b hp=%b busy=%b done=%b want %b/%b/%b/%b", c,
                         vertical_Sync, horizontal_Pulse, busy, frame_Done, exp_vsync, exp_pulse, exp_busy, exp_done);
            end
            if (exp_active || exp_zero) begin
                checks++;
                if (row_Index !== RB'(exp_row) || col_Index !== CB'(exp_col) || pixel_Address !== AB'(exp_addr)) begin
                    errors++;
                    $display("FAIL rand_pos cycle=%0d got row=%0d col=%0d addr=%0d want %0d/%0d/%0d", c,
                             row_Index, col_Index, pixel_Address, exp_row, exp_col, exp_addr);
                end
            end
            if (vertical_Sync && !vs_prev) cnt = 0;
            if (!busy) cnt = 0;
            vs_prev = vertical_Sync;
            if (horizontal_Pulse) cnt++;
            if (frame_Done) begin
                frames++;
                checks++;
                if (cnt != N) begin
                    errors++;
                    $display("FAIL rand_frame_pulses got=%0d want=%0d", cnt, N);
                end
            end
        end
        $display("test_random_stall done frames=%0d", frames);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_pulse();
        test_full_frame();
        test_stall();
        test_back_to_back();
        test_reset_abort();
        test_random_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
